rv_seq_alu: RTL and testbench

//  Parametrised, handshaked successor to the RV32I combinational ALU; sits between decode and writeback.
//  Add/sub, logic and SLT/SLTU complete in 1 cycle.

---
 rtl/rv_alu_pkg.sv | 22 ++
 rtl/rv_alu_shift_step.sv | 25 ++
 rtl/rv_seq_alu.sv | 215 +++++++++++++++++++++
 tb/tb_rv_seq_alu.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_alu_pkg.sv
// Shared RV32I ALU definitions: funct3 encodings, FSM state codes, op helpers.
package rv_alu_pkg;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   // True for the funct3 codes that select a shift
   function automatic logic is_shift_op(input logic [2:0] f3);
      return (f3 == F3_SLL) || (f3 == F3_SR);
   endfunction

endpackage

// File: rtl/rv_alu_shift_step.sv
// Combinational shifter: one step of up to 2^AW-1 positions, left or right,
// logical or arithmetic. Used as the per-cycle step or as a full barrel shifter.
module rv_alu_shift_step #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 5
) (
   input  logic [XLEN-1:0] data,
   input  logic [AW-1:0]   amount,
   input  logic            left,
   input  logic            arith,
   output logic [XLEN-1:0] shifted_c
);

   // Direction/fill selection; left shifts always fill with zero
   always_comb begin
      if (left) begin
         shifted_c = data << amount;
      end else if (arith) begin
         shifted_c = XLEN'($signed(data) >>> amount);
      end else begin
         shifted_c = data >> amount;
      end
   end

endmodule

// File: rtl/rv_seq_alu.sv
// Handshaked RV32I ALU. Single-cycle add/sub/logic/compare; shifts iterate
// SHIFT_STEP positions per cycle. Define SEQ_ALU_BARREL_EN for a single-cycle
// barrel shifter instead (SHIFT state never used, SHIFT_STEP ignored).
module rv_seq_alu
   import rv_alu_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned SHIFT_STEP = 1
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [2:0]      funct3,
   input  logic            op_sign,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            negative,
   output logic            overflow,
   output logic            busy
);

   localparam int unsigned SW = $clog2(XLEN);
`ifdef SEQ_ALU_BARREL_EN
   localparam int unsigned AW = SW;
`else
   localparam int unsigned AW = $clog2(SHIFT_STEP + 1);
`endif

   logic [1:0]      state, state_nxt;
   logic            out_valid_nxt, zero_nxt, negative_nxt, overflow_nxt;
   logic [XLEN-1:0] result_nxt;
   logic            accept_c;
   logic [SW-1:0]   shamt;
   logic [XLEN-1:0] b_eff, sum, op_res;
   logic            op_ovf;
   logic [AW-1:0]   step_amt;
   logic [XLEN-1:0] step_in, step_out;
   logic            step_left, step_arith;

   assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
   assign busy     = (state != S_IDLE);
   assign accept_c = in_valid & in_ready;
   assign shamt    = op_b[SW-1:0];

`ifndef SEQ_ALU_BARREL_EN
   logic [XLEN-1:0] sh_data, sh_data_nxt;
   logic [SW-1:0]   sh_rem, sh_rem_nxt, sh_rem_dec;
   logic            sh_left, sh_left_nxt, sh_arith, sh_arith_nxt;

   // Step size is SHIFT_STEP, trimmed on the final partial step
   always_comb begin
      if (32'(sh_rem) < SHIFT_STEP) step_amt = AW'(sh_rem);
      else                          step_amt = AW'(SHIFT_STEP);
   end

   assign step_in    = sh_data;
   assign step_left  = sh_left;
   assign step_arith = sh_arith;
   assign sh_rem_dec = sh_rem - SW'(step_amt);

   // Iterative shift working registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sh_data  <= '0;
         sh_rem   <= '0;
         sh_left  <= 1'b0;
         sh_arith <= 1'b0;
      end else begin
         sh_data  <= sh_data_nxt;
         sh_rem   <= sh_rem_nxt;
         sh_left  <= sh_left_nxt;
         sh_arith <= sh_arith_nxt;
      end
   end
`else
   assign step_amt   = shamt;
   assign step_in    = op_a;
   assign step_left  = (funct3 == F3_SLL);
   assign step_arith = op_sign;
`endif

   rv_alu_shift_step #(
      .XLEN (XLEN),
      .AW   (AW)
   ) u_shift (
      .data      (step_in),
      .amount    (step_amt),
      .left      (step_left),
      .arith     (step_arith),
      .shifted_c (step_out)
   );

   // Single-cycle datapath on the live inputs, used at accept
   always_comb begin
      b_eff  = ((funct3 == F3_ADD) & op_sign) ? (~op_b + XLEN'(1)) : op_b;
      sum    = op_a + b_eff;
      op_ovf = 1'b0;
      op_res = '0;
      case (funct3)
         F3_ADD: begin
            op_res = sum;
            op_ovf = (op_a[XLEN-1] == b_eff[XLEN-1]) & (sum[XLEN-1] != op_a[XLEN-1]);
         end
         F3_SLT:  op_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         F3_SLTU: op_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         F3_XOR:  op_res = op_a ^ op_b;
         F3_OR:   op_res = op_a | op_b;
         F3_AND:  op_res = op_a & op_b;
`ifdef SEQ_ALU_BARREL_EN
         F3_SLL, F3_SR: op_res = step_out;
`else
         // Only reached with shamt == 0; nonzero shifts go through SHIFT
         F3_SLL, F3_SR: op_res = op_a;
`endif
         default: op_res = '0;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_nxt     = state;
      out_valid_nxt = out_valid;
      result_nxt    = result;
      zero_nxt      = zero;
      negative_nxt  = negative;
      overflow_nxt  = overflow;
`ifndef SEQ_ALU_BARREL_EN
      sh_data_nxt   = sh_data;
      sh_rem_nxt    = sh_rem;
      sh_left_nxt   = sh_left;
      sh_arith_nxt  = sh_arith;
`endif
      case (state)
         S_IDLE: ;
         S_SHIFT: begin
`ifndef SEQ_ALU_BARREL_EN
            sh_data_nxt = step_out;
            sh_rem_nxt  = sh_rem_dec;
            if (sh_rem_dec == '0) begin
               state_nxt     = S_DONE;
               out_valid_nxt = 1'b1;
               result_nxt    = step_out;
               zero_nxt      = (step_out == '0);
               negative_nxt  = step_out[XLEN-1];
               overflow_nxt  = 1'b0;
            end
`else
            state_nxt = S_IDLE;
`endif
         end
         S_DONE: begin
            if (out_ready) begin
               state_nxt     = S_IDLE;
               out_valid_nxt = 1'b0;
               result_nxt    = '0;
               zero_nxt      = 1'b0;
               negative_nxt  = 1'b0;
               overflow_nxt  = 1'b0;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // A new accept overrides the retire path (back-to-back issue)
      if (accept_c) begin
`ifndef SEQ_ALU_BARREL_EN
         if (is_shift_op(funct3) && (shamt != '0)) begin
            state_nxt     = S_SHIFT;
            out_valid_nxt = 1'b0;
            result_nxt    = '0;
            zero_nxt      = 1'b0;
            negative_nxt  = 1'b0;
            overflow_nxt  = 1'b0;
            sh_data_nxt   = op_a;
            sh_rem_nxt    = shamt;
            sh_left_nxt   = (funct3 == F3_SLL);
            sh_arith_nxt  = op_sign;
         end else
`endif
         begin
            state_nxt     = S_DONE;
            out_valid_nxt = 1'b1;
            result_nxt    = op_res;
            zero_nxt      = (op_res == '0);
            negative_nxt  = op_res[XLEN-1];
            overflow_nxt  = op_ovf;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         negative  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_nxt;
         out_valid <= out_valid_nxt;
         result    <= result_nxt;
         zero      <= zero_nxt;
         negative  <= negative_nxt;
         overflow  <= overflow_nxt;
      end
   end

endmodule

// File: tb/tb_rv_seq_alu.sv
// Self-checking bench for rv_seq_alu: two instances (SHIFT_STEP 1 and 4)
// driven by directed and random ops, checked against a behavioural model.
module tb_rv_seq_alu;
   import rv_alu_pkg::*;

   localparam int unsigned STEP0 = 1;
   localparam int unsigned STEP1 = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid [2];
   logic        in_ready [2];
   logic        out_valid[2];
   logic        out_ready[2];
   logic        op_sign  [2];
   logic        zero     [2];
   logic        negative [2];
   logic        overflow [2];
   logic        busy     [2];
   logic [31:0] op_a     [2];
   logic [31:0] op_b     [2];
   logic [31:0] result   [2];
   logic [2:0]  funct3   [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rv_seq_alu #(.XLEN(32), .SHIFT_STEP(STEP0)) u_dut0 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .op_a(op_a[0]), .op_b(op_b[0]), .funct3(funct3[0]), .op_sign(op_sign[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]),
      .zero(zero[0]), .negative(negative[0]), .overflow(overflow[0]), .busy(busy[0])
   );

   rv_seq_alu #(.XLEN(32), .SHIFT_STEP(STEP1)) u_dut1 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .op_a(op_a[1]), .op_b(op_b[1]), .funct3(funct3[1]), .op_sign(op_sign[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]),
      .zero(zero[1]), .negative(negative[1]), .overflow(overflow[1]), .busy(busy[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: plain arithmetic on the operands plus the latency rule
   function automatic void ref_alu(input int d, input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] f3, input logic sg,
                                   output logic [31:0] r, output logic ov, output int lat);
      int          n;
      int          step;
      logic [31:0] bb;
      n    = int'(b[4:0]);
      step = (d == 0) ? int'(STEP0) : int'(STEP1);
      ov   = 1'b0;
      lat  = 1;
      r    = 32'h0;
      case (f3)
         F3_ADD: begin
            bb = sg ? (32'h0 - b) : b;
            r  = a + bb;
            ov = (a[31] == bb[31]) && (r[31] != a[31]);
         end
         F3_SLL:  r = a << n;
         F3_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         F3_SLTU: r = (a < b) ? 32'd1 : 32'd0;
         F3_XOR:  r = a ^ b;
         F3_SR:   r = sg ? 32'($signed(a) >>> n) : (a >> n);
         F3_OR:   r = a | b;
         default: r = a & b;
      endcase
`ifndef SEQ_ALU_BARREL_EN
      if (((f3 == F3_SLL) || (f3 == F3_SR)) && (n != 0)) lat = 1 + (n + step - 1) / step;
`endif
   endfunction

   // Issue one op at a negedge, measure latency, check result and flags,
   // optionally stall the consumer; returns at a negedge with out_ready=1.
   task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic sg, input int stall, input string tag);
      logic [31:0] er;
      logic        eo;
      int          elat;
      int          cyc;
      ref_alu(d, a, b, f3, sg, er, eo, elat);
      op_a[d] = a; op_b[d] = b; funct3[d] = f3; op_sign[d] = sg; in_valid[d] = 1'b1;
      cyc = 0;
      while (!in_ready[d] && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_acc"}, 32'(in_ready[d]), 32'd1);
      @(posedge clk);
      #1;
      in_valid[d]  = 1'b0;
      out_ready[d] = (stall == 0);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!out_valid[d] && cyc < 200);
      check({tag, "_lat"}, 32'(cyc), 32'(elat));
      check({tag, "_res"}, result[d], er);
      check({tag, "_zero"}, 32'(zero[d]), 32'(er == 32'h0));
      check({tag, "_neg"}, 32'(negative[d]), 32'(er[31]));
      check({tag, "_ovf"}, 32'(overflow[d]), 32'(eo));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({tag, "_hold_res"}, result[d], er);
         check({tag, "_hold_vld"}, 32'(out_valid[d]), 32'd1);
         check({tag, "_hold_rdy"}, 32'(in_ready[d]), 32'd0);
      end
      out_ready[d] = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [2:0]  f3;
      logic [31:0] ra, rb;
      resetn = 1'b0;
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0; out_ready[d] = 1'b1; op_sign[d] = 1'b0;
         op_a[d] = 32'h0; op_b[d] = 32'h0; funct3[d] = F3_ADD;
      end
      repeat (3) @(negedge clk);

      // Reset state
      for (int d = 0; d < 2; d++) begin
         check("rst_vld",  32'(out_valid[d]), 32'd0);
         check("rst_res",  result[d], 32'h0);
         check("rst_zero", 32'(zero[d]), 32'd0);
         check("rst_busy", 32'(busy[d]), 32'd0);
         check("rst_rdy",  32'(in_ready[d]), 32'd1);
      end
      resetn = 1'b1;
      @(negedge clk);

      // Directed cases
      do_op(0, 32'd12, 32'd13, F3_ADD, 1'b0, 0, "add");
      do_op(0, 32'h8000_0000, 32'd1, F3_ADD, 1'b1, 0, "sub_ovf");
      do_op(0, 32'd11, 32'd13, F3_ADD, 1'b1, 0, "sub_neg");
      do_op(0, 32'hFFFF_0001, 32'd2, F3_SR, 1'b1, 0, "sra2");
      do_op(1, 32'h1000_0000, 32'd7, F3_SR, 1'b0, 0, "srl7_s4");
      do_op(0, 32'hFFFF_FFEE, 32'd14, F3_SLT, 1'b0, 0, "slt");
      do_op(0, 32'hFFFF_FFEE, 32'd14, F3_SLTU, 1'b0, 0, "sltu");
      do_op(0, 32'h1000_0000, 32'd0, F3_SLL, 1'b0, 0, "sll0");
      do_op(0, 32'h0000_0001, 32'd31, F3_SLL, 1'b0, 0, "sll31");
      do_op(1, 32'h8000_0000, 32'd31, F3_SR, 1'b1, 0, "sra31_s4");
      do_op(0, 32'h5, 32'h5, F3_XOR, 1'b0, 0, "xor_zero");

      // Consumer stall, then back-to-back accept with no bubble
      do_op(0, 32'd100, 32'd23, F3_ADD, 1'b0, 5, "stall");
      do_op(0, 32'd1, 32'd2, F3_ADD, 1'b0, 0, "b2b");

      // Asynchronous reset in the middle of a shift
      check("mid_rdy", 32'(in_ready[0]), 32'd1);
      op_a[0] = 32'h8000_0000; op_b[0] = 32'd20; funct3[0] = F3_SR; op_sign[0] = 1'b0;
      in_valid[0] = 1'b1;
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_busy", 32'(busy[0]), 32'd1);
      check("mid_vld",  32'(out_valid[0]), 32'd0);
      check("mid_res",  result[0], 32'h0);
      #2 resetn = 1'b0;
      #1;
      check("arst_vld",  32'(out_valid[0]), 32'd0);
      check("arst_busy", 32'(busy[0]), 32'd0);
      check("arst_rdy",  32'(in_ready[0]), 32'd1);
      check("arst_res",  result[0], 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      do_op(0, 32'h0F0F_0F0F, 32'h00FF_00FF, F3_AND, 1'b0, 0, "post_rst");

      // Randomized ops on both instances
      for (int i = 0; i < 60; i++) begin
         f3 = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
         if ($urandom_range(0, 4) == 0) rb = ra;
         do_op(i % 2, ra, rb, f3, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, "rnd");
         repeat ($urandom_range(0, 1)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
